// File: rtl/dbg_uart_pkg.sv
// Shared definitions for the UART debug command path.
// Contents: parser state encoding, ASCII constants, error codes and
// small byte-classification helpers.
package dbg_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARG   = 2'd1,
    DONE  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_CMD  = 2'd1,
    ERR_OVF  = 2'd2,
    ERR_DIG  = 2'd3
  } err_code_e;

  localparam logic [7:0] CH_SP = 8'h20;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;

  function automatic logic is_term(input logic [7:0] b);
    return (b == CH_CR) || (b == CH_LF);
  endfunction

  function automatic logic is_lower(input logic [7:0] b);
    return (b >= 8'h61) && (b <= 8'h7A);
  endfunction

endpackage

// File: rtl/ascii_nibble_decode.sv
// Combinational ASCII-to-nibble decoder (lowercase hex only).
// Ports:
//   in     - ASCII byte
//   nib    - decoded 4-bit value, 0 when the byte is not a hex digit
//   is_hex - byte is one of 0-9 or a-f
module ascii_nibble_decode (
  input  logic [7:0] in,
  output logic [3:0] nib,
  output logic       is_hex
);

  always_comb begin
    nib    = '0;
    is_hex = 1'b0;
    if (in >= 8'h30 && in <= 8'h39) begin
      nib    = 4'(in - 8'h30);
      is_hex = 1'b1;
    end else if (in >= 8'h61 && in <= 8'h66) begin
      nib    = 4'(in - 8'h57);
      is_hex = 1'b1;
    end
  end

endmodule

// File: rtl/hex_cmd_parser.sv
// Byte-serial debug command parser: one lowercase command letter, up to
// MAX_DIGITS lowercase hex digits, then CR or LF. The completed command is
// held under a valid/ack handshake.
// Ports:
//   clk, rst_n          - clock, synchronous active-low reset
//   rx_data/rx_valid    - incoming byte stream
//   rx_ready            - byte accepted when rx_valid & rx_ready
//   cmd_char/cmd_value  - latched command letter and argument
//   cmd_digits          - number of argument digits
//   cmd_valid/cmd_ack   - command handshake
//   err/err_code        - one-cycle error pulse and held cause
module hex_cmd_parser
  import dbg_uart_pkg::*;
#(
  parameter int unsigned MAX_DIGITS = 8,
  parameter int unsigned VAL_W      = 4 * MAX_DIGITS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             rx_ready,
  output logic [7:0]       cmd_char,
  output logic [VAL_W-1:0] cmd_value,
  output logic [3:0]       cmd_digits,
  output logic             cmd_valid,
  input  logic             cmd_ack,
  output logic             err,
  output logic [1:0]       err_code
);

  state_e           state_q, state_d;
  logic [7:0]       cmd_char_q, cmd_char_d;
  logic [VAL_W-1:0] cmd_value_q, cmd_value_d;
  logic [3:0]       cmd_digits_q, cmd_digits_d;
  logic             cmd_valid_q, cmd_valid_d;
  logic             err_q, err_d;
  logic [1:0]       err_code_q, err_code_d;

  logic [3:0]       hex_nib;
  logic             hex_ok;
  logic             xfer;
  // Widened concat avoids a negative slice bound when MAX_DIGITS == 1.
  logic [VAL_W+3:0] shifted;

  ascii_nibble_decode u_dec (
    .in     (rx_data),
    .nib    (hex_nib),
    .is_hex (hex_ok)
  );

  assign rx_ready = (state_q != DONE);
  assign xfer     = rx_valid & rx_ready;
  assign shifted  = {cmd_value_q, hex_nib};

  always_comb begin
    state_d      = state_q;
    cmd_char_d   = cmd_char_q;
    cmd_value_d  = cmd_value_q;
    cmd_digits_d = cmd_digits_q;
    cmd_valid_d  = cmd_valid_q;
    err_d        = 1'b0;
    err_code_d   = err_code_q;

    case (state_q)
      IDLE: begin
        if (xfer) begin
          if (rx_data == CH_SP || is_term(rx_data)) begin
            // separators and stray terminators are ignored
          end else if (is_lower(rx_data)) begin
            cmd_char_d   = rx_data;
            cmd_value_d  = '0;
            cmd_digits_d = '0;
            state_d      = ARG;
          end else begin
            err_d      = 1'b1;
            err_code_d = ERR_CMD;
            state_d    = DRAIN;
          end
        end
      end
      ARG: begin
        if (xfer) begin
          if (is_term(rx_data)) begin
            cmd_valid_d = 1'b1;
            state_d     = DONE;
          end else if (rx_data == CH_SP && cmd_digits_q == '0) begin
            // separator between letter and first digit
          end else if (hex_ok) begin
            if (cmd_digits_q == 4'(MAX_DIGITS)) begin
              err_d      = 1'b1;
              err_code_d = ERR_OVF;
              state_d    = DRAIN;
            end else begin
              cmd_value_d  = shifted[VAL_W-1:0];
              cmd_digits_d = cmd_digits_q + 4'd1;
            end
          end else begin
            err_d      = 1'b1;
            err_code_d = ERR_DIG;
            state_d    = DRAIN;
          end
        end
      end
      DONE: begin
        if (cmd_valid_q && cmd_ack) begin
          cmd_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      DRAIN: begin
        if (xfer && is_term(rx_data)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cmd_char_q   <= '0;
      cmd_value_q  <= '0;
      cmd_digits_q <= '0;
      cmd_valid_q  <= 1'b0;
      err_q        <= 1'b0;
      err_code_q   <= ERR_NONE;
    end else begin
      state_q      <= state_d;
      cmd_char_q   <= cmd_char_d;
      cmd_value_q  <= cmd_value_d;
      cmd_digits_q <= cmd_digits_d;
      cmd_valid_q  <= cmd_valid_d;
      err_q        <= err_d;
      err_code_q   <= err_code_d;
    end
  end

  assign cmd_char   = cmd_char_q;
  assign cmd_value  = cmd_value_q;
  assign cmd_digits = cmd_digits_q;
  assign cmd_valid  = cmd_valid_q;
  assign err        = err_q;
  assign err_code   = err_code_q;

endmodule

// File: tb/tb_hex_cmd_parser.sv
module tb_hex_cmd_parser;

  localparam int MAXD = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  cmd_char;
  logic [31:0] cmd_value;
  logic [3:0]  cmd_digits;
  logic        cmd_valid;
  logic        cmd_ack = 1'b0;
  logic        err;
  logic [1:0]  err_code;

  int errors = 0;
  int checks = 0;
  logic [1:0] last_code = 2'd0;
  logic [7:0] line_q[$];

  always #5 clk = ~clk;

  hex_cmd_parser #(.MAX_DIGITS(8), .VAL_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .cmd_char   (cmd_char),
    .cmd_value  (cmd_value),
    .cmd_digits (cmd_digits),
    .cmd_valid  (cmd_valid),
    .cmd_ack    (cmd_ack),
    .err        (err),
    .err_code   (err_code)
  );

  // Reference model: scans a whole line (ending in CR/LF) and states the
  // outcome directly from the command-line grammar.
  task automatic model_line(output int err_idx, output logic [1:0] code,
                            output bit valid, output logic [7:0] ch,
                            output logic [31:0] val, output int nd);
    int i;
    logic [7:0] c;
    longint unsigned acc;
    i = 0; acc = 0;
    err_idx = -1; code = 2'd0; valid = 0; ch = 8'h00; val = '0; nd = 0;
    while (i < line_q.size() &&
           (line_q[i] == 8'h20 || line_q[i] == 8'h0D || line_q[i] == 8'h0A)) i++;
    if (i >= line_q.size()) return;
    c = line_q[i];
    if (!(c >= 8'h61 && c <= 8'h7A)) begin
      err_idx = i; code = 2'd1; return;
    end
    ch = c;
    i++;
    while (i < line_q.size()) begin
      c = line_q[i];
      if (c == 8'h0D || c == 8'h0A) begin
        valid = 1; val = 32'(acc); return;
      end
      if (c == 8'h20 && nd == 0) begin
      end else if ((c >= 8'h30 && c <= 8'h39) || (c >= 8'h61 && c <= 8'h66)) begin
        if (nd == MAXD) begin
          err_idx = i; code = 2'd2; return;
        end
        acc = acc * 16 + ((c <= 8'h39) ? longint'(c - 8'h30) : longint'(c - 8'h61 + 10));
        nd++;
      end else begin
        err_idx = i; code = 2'd3; return;
      end
      i++;
    end
  endtask

  task automatic load_str(input string s);
    line_q.delete();
    for (int i = 0; i < s.len(); i++) line_q.push_back(s[i]);
  endtask

  // Drive one byte; returns #1 after the transfer edge.
  task automatic send_byte(input logic [7:0] b);
    int cnt;
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    cnt = 0;
    while (!rx_ready && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    checks++;
    if (!rx_ready) begin
      errors++;
      $display("FAIL send_timeout: rx_ready=%0b required 1", rx_ready);
    end
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic do_ack();
    @(negedge clk);
    cmd_ack = 1'b1;
    @(posedge clk);
    #1;
    cmd_ack = 1'b0;
    checks++;
    if (cmd_valid !== 1'b0) begin
      errors++; $display("FAIL ack_clear: cmd_valid=%0b required 0", cmd_valid);
    end
    checks++;
    if (rx_ready !== 1'b1) begin
      errors++; $display("FAIL ack_ready: rx_ready=%0b required 1", rx_ready);
    end
  endtask

  // Send line_q, check against the model; ack_delay<0 leaves the command pending.
  task automatic run_line(input bit stall, input int ack_delay);
    int eidx, nd;
    logic [1:0] code;
    bit valid;
    logic [7:0] ch;
    logic [31:0] val;
    model_line(eidx, code, valid, ch, val, nd);
    for (int i = 0; i < line_q.size(); i++) begin
      if (stall) begin
        repeat ($urandom_range(0, 2)) begin
          @(negedge clk);
          rx_valid = 1'b0;
          rx_data  = 8'($urandom);
        end
      end
      send_byte(line_q[i]);
      checks++;
      if (err !== (i == eidx)) begin
        errors++; $display("FAIL err_pulse: byte %0d err=%0b required %0b", i, err, (i == eidx));
      end
      if (i == eidx) begin
        last_code = code;
        checks++;
        if (err_code !== code) begin
          errors++; $display("FAIL err_code: got %0d required %0d", err_code, code);
        end
      end
    end
    checks++;
    if (cmd_valid !== valid) begin
      errors++; $display("FAIL cmd_valid: got %0b required %0b", cmd_valid, valid);
    end
    checks++;
    if (err_code !== last_code) begin
      errors++; $display("FAIL err_code_hold: got %0d required %0d", err_code, last_code);
    end
    if (valid) begin
      checks++;
      if (cmd_char !== ch || cmd_value !== val || cmd_digits !== 4'(nd)) begin
        errors++;
        $display("FAIL cmd_fields: got %h/%h/%0d required %h/%h/%0d",
                 cmd_char, cmd_value, cmd_digits, ch, val, nd);
      end
      if (ack_delay >= 0) begin
        repeat (ack_delay) begin
          @(posedge clk);
          #1;
          checks++;
          if (cmd_valid !== 1'b1 || rx_ready !== 1'b0 || cmd_value !== val) begin
            errors++;
            $display("FAIL hold_done: valid=%0b ready=%0b value=%h required 1/0/%h",
                     cmd_valid, rx_ready, cmd_value, val);
          end
        end
        do_ack();
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (cmd_char !== 8'h00 || cmd_value !== 32'h0 || cmd_digits !== 4'd0 ||
        cmd_valid !== 1'b0 || err !== 1'b0 || err_code !== 2'd0 || rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: char=%h val=%h dig=%0d valid=%0b err=%0b code=%0d ready=%0b required all 0, ready 1",
               cmd_char, cmd_value, cmd_digits, cmd_valid, err, err_code, rx_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    last_code = 2'd0;
  endtask

  task automatic test_basic();
    load_str("w 1a2b"); line_q.push_back(8'h0D);
    run_line(0, 3);
  endtask

  task automatic test_zero_digits();
    load_str("r"); line_q.push_back(8'h0A);
    run_line(0, 1);
  endtask

  task automatic test_overflow();
    load_str("w 123456789"); line_q.push_back(8'h0D);
    run_line(0, 0);
    load_str("r 5"); line_q.push_back(8'h0D);
    run_line(0, 0);
  endtask

  task automatic test_bad_chars();
    load_str("w 1F"); line_q.push_back(8'h0D);
    run_line(0, 0);
    load_str("W"); line_q.push_back(8'h0D);
    run_line(0, 0);
  endtask

  task automatic test_back_to_back();
    load_str("r ff"); line_q.push_back(8'h0D);
    run_line(0, -1);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = 8'h61;
    repeat (10) begin
      @(posedge clk);
      #1;
      checks++;
      if (rx_ready !== 1'b0 || cmd_valid !== 1'b1 || cmd_char !== 8'h72 ||
          cmd_value !== 32'hFF || cmd_digits !== 4'd2) begin
        errors++;
        $display("FAIL backpressure: ready=%0b valid=%0b %h/%h/%0d required 0/1 72/000000ff/2",
                 rx_ready, cmd_valid, cmd_char, cmd_value, cmd_digits);
      end
    end
    @(negedge clk);
    cmd_ack = 1'b1;
    @(posedge clk);
    #1;
    cmd_ack = 1'b0;
    checks++;
    if (cmd_valid !== 1'b0 || rx_ready !== 1'b1) begin
      errors++; $display("FAIL bp_ack: valid=%0b ready=%0b required 0/1", cmd_valid, rx_ready);
    end
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    checks++;
    if (cmd_char !== 8'h61 || cmd_digits !== 4'd0 || cmd_value !== 32'h0) begin
      errors++;
      $display("FAIL bp_new_cmd: %h/%h/%0d required 61/00000000/0", cmd_char, cmd_value, cmd_digits);
    end
    send_byte(8'h0D);
    checks++;
    if (cmd_valid !== 1'b1 || cmd_char !== 8'h61) begin
      errors++; $display("FAIL bp_term: valid=%0b char=%h required 1/61", cmd_valid, cmd_char);
    end
    do_ack();
  endtask

  task automatic test_reset_mid();
    load_str("w 12");
    foreach (line_q[i]) send_byte(line_q[i]);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (cmd_char !== 8'h00 || cmd_value !== 32'h0 || cmd_digits !== 4'd0 ||
        cmd_valid !== 1'b0 || err !== 1'b0 || err_code !== 2'd0 || rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid: char=%h val=%h dig=%0d valid=%0b err=%0b code=%0d ready=%0b required all 0, ready 1",
               cmd_char, cmd_value, cmd_digits, cmd_valid, err, err_code, rx_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    last_code = 2'd0;
    load_str("r 3"); line_q.push_back(8'h0D);
    run_line(0, 0);
  endtask

  task automatic test_random();
    int nd, d, pos;
    logic [7:0] bad;
    for (int n = 0; n < 40; n++) begin
      line_q.delete();
      if ($urandom_range(0, 9) == 0) line_q.push_back(8'(8'h41 + $urandom_range(0, 25)));
      else                           line_q.push_back(8'(8'h61 + $urandom_range(0, 25)));
      repeat ($urandom_range(0, 2)) line_q.push_back(8'h20);
      nd = $urandom_range(0, 9);
      for (int k = 0; k < nd; k++) begin
        d = $urandom_range(0, 15);
        line_q.push_back((d < 10) ? 8'(8'h30 + d) : 8'(8'h61 + d - 10));
      end
      if ($urandom_range(0, 5) == 0) begin
        case ($urandom_range(0, 4))
          0: bad = 8'h47;
          1: bad = 8'h41;
          2: bad = 8'h7A;
          3: bad = 8'h20;
          default: bad = 8'h2E;
        endcase
        pos = $urandom_range(1, line_q.size());
        line_q.insert(pos, bad);
      end
      line_q.push_back($urandom_range(0, 1) ? 8'h0D : 8'h0A);
      run_line(1, $urandom_range(0, 3));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_digits();
    test_overflow();
    test_bad_chars();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
